// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake score path
package snake_pkg;

    localparam int SCORE_W           = 7;
    localparam int MAX_SCORE_DEFAULT = 50;
    localparam int DISP_MAX          = 99;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SHOW_FINAL,
        SHOW_HIGH
    } flow_state_t;

    // Two 7-segment digits cannot show more than 99, so saturate there.
    function automatic logic [SCORE_W-1:0] clamp_disp(input logic [SCORE_W-1:0] v);
        return (v > SCORE_W'(DISP_MAX)) ? SCORE_W'(DISP_MAX) : v;
    endfunction

endpackage

// File: rtl/bin2bcd7.sv
// rtl/bin2bcd7.sv - combinational 7-bit binary to two-digit BCD, valid for 0..99
module bin2bcd7
    import snake_pkg::*;
(
    input  logic [SCORE_W-1:0] value,
    output logic [3:0]         tens,
    output logic [3:0]         ones
);

    logic [3:0] rem;

    // Largest multiple of ten not above value picks the tens digit.
    always_comb begin
        tens = 4'd0;
        rem  = 4'(value);
        for (int i = 1; i <= 9; i++) begin
            if (value >= SCORE_W'(10 * i)) begin
                tens = 4'(i);
                rem  = 4'(value - SCORE_W'(10 * i));
            end
        end
        ones = rem;
    end

endmodule

// File: rtl/score_flow_ctrl.sv
// rtl/score_flow_ctrl.sv - game-flow sequencer: collision pulses, game start/end, final-score blink
module score_flow_ctrl
    import snake_pkg::*;
#(
    parameter int FLASH_TICKS  = 4,
    parameter int HOLD_FLASHES = 3,
    parameter int MAX_SCORE    = MAX_SCORE_DEFAULT
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               tick,
    input  logic               start,
    input  logic               eat_evt,
    input  logic               crash_evt,
    input  logic [SCORE_W-1:0] score_cur,
    input  logic [SCORE_W-1:0] score_high,
    output logic               good_coll,
    output logic               bad_coll,
    output logic               game_active,
    output logic               game_won,
    output logic               disp_blank,
    output logic [SCORE_W-1:0] disp_value,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_ones
);

    localparam int TICK_W  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int FLASH_W = $clog2(HOLD_FLASHES + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FLASH_TICKS - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(HOLD_FLASHES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(MAX_SCORE);

    flow_state_t        state, state_nx;
    logic [TICK_W-1:0]  tick_cnt;
    logic [FLASH_W-1:0] flash_cnt;
    logic [SCORE_W-1:0] final_q;
    logic [SCORE_W-1:0] disp_mux;
    logic [SCORE_W-1:0] disp_clamped;
    logic [3:0]         tens_nx;
    logic [3:0]         ones_nx;
    logic               crash_in_play;
    logic               win_in_play;
    logic               half_done;
    logic               seq_done;

    // A crash outranks both a simultaneous eat and a max-score win.
    always_comb begin
        crash_in_play = (state == PLAY) && crash_evt;
        win_in_play   = (state == PLAY) && !crash_evt && (score_cur >= WIN_SCORE);
        half_done     = (state == SHOW_FINAL) && tick && (tick_cnt == TICK_LAST);
        seq_done      = half_done && disp_blank && (flash_cnt == FLASH_LAST);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start) state_nx = PLAY;
            PLAY:       if (crash_in_play || win_in_play) state_nx = SHOW_FINAL;
            SHOW_FINAL: if (seq_done) state_nx = SHOW_HIGH;
            SHOW_HIGH:  if (start) state_nx = PLAY;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            good_coll   <= 1'b0;
            bad_coll    <= 1'b0;
            game_active <= 1'b0;
            game_won    <= 1'b0;
            final_q     <= '0;
        end else begin
            good_coll   <= (state == PLAY) && eat_evt && !crash_evt && !win_in_play;
            bad_coll    <= crash_in_play;
            game_active <= (state_nx == PLAY);
            if (crash_in_play || win_in_play) begin
                final_q <= score_cur;
            end
            if (win_in_play) begin
                game_won <= 1'b1;
            end else if (state != PLAY && state_nx == PLAY) begin
                game_won <= 1'b0;
            end
        end
    end

    // Counters only run while staying in SHOW_FINAL, so entry and exit both leave them cleared.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tick_cnt   <= '0;
            flash_cnt  <= '0;
            disp_blank <= 1'b0;
        end else if (state != SHOW_FINAL || state_nx != SHOW_FINAL) begin
            tick_cnt   <= '0;
            flash_cnt  <= '0;
            disp_blank <= 1'b0;
        end else if (tick) begin
            if (half_done) begin
                tick_cnt   <= '0;
                disp_blank <= !disp_blank;
                if (disp_blank) begin
                    flash_cnt <= flash_cnt + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (state)
            PLAY:       disp_mux = score_cur;
            SHOW_FINAL: disp_mux = final_q;
            default:    disp_mux = score_high;
        endcase
        disp_clamped = clamp_disp(disp_mux);
    end

    bin2bcd7 u_bcd (
        .value (disp_clamped),
        .tens  (tens_nx),
        .ones  (ones_nx)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            disp_value <= '0;
            bcd_tens   <= 4'd0;
            bcd_ones   <= 4'd0;
        end else begin
            disp_value <= disp_clamped;
            bcd_tens   <= tens_nx;
            bcd_ones   <= ones_nx;
        end
    end

endmodule

// File: tb/tb_score_flow_ctrl.sv
// tb/tb_score_flow_ctrl.sv - scoreboard bench for score_flow_ctrl
module tb_score_flow_ctrl;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       nRst, tick, start, eat_evt, crash_evt;
    logic [6:0] score_cur, score_high;
    logic       good_coll, bad_coll, game_active, game_won, disp_blank;
    logic [6:0] disp_value;
    logic [3:0] bcd_tens, bcd_ones;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic tick_en = 1'b0;
    logic blank_prev = 1'b0;
    int   crash_cyc;
    int   first_tick_edge;
    int   budget;

    typedef struct {
        logic good;
        logic bad;
        int   at;
    } coll_t;

    coll_t exp_q[$];
    coll_t exp_e;
    int    toggle_q[$];

    score_flow_ctrl #(.FLASH_TICKS(4), .HOLD_FLASHES(3), .MAX_SCORE(50)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .tick        (tick),
        .start       (start),
        .eat_evt     (eat_evt),
        .crash_evt   (crash_evt),
        .score_cur   (score_cur),
        .score_high  (score_high),
        .good_coll   (good_coll),
        .bad_coll    (bad_coll),
        .game_active (game_active),
        .game_won    (game_won),
        .disp_blank  (disp_blank),
        .disp_value  (disp_value),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_eat();
        eat_evt = 1'b1;
        exp_q.push_back('{good: 1'b1, bad: 1'b0, at: cyc + 1});
        step(1);
        eat_evt = 1'b0;
    endtask

    task automatic wait_toggles(input string tag, input int n);
        budget = 0;
        while (toggle_q.size() < n && budget < 400) begin
            step(1);
            budget++;
        end
        check(tag, toggle_q.size(), n);
    endtask

    // Collision pulses are popped against the scoreboard; blank edges are logged.
    always @(negedge clk) begin
        if (good_coll || bad_coll) begin
            check("coll_exclusive", int'(good_coll & bad_coll), 0);
            if (exp_q.size() == 0) begin
                check("coll_unexpected", int'(good_coll | bad_coll), 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("coll_good", good_coll, exp_e.good);
                check("coll_bad", bad_coll, exp_e.bad);
                check("coll_cycle", cyc, exp_e.at);
            end
        end
        if (disp_blank != blank_prev) toggle_q.push_back(cyc);
        blank_prev = disp_blank;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = tick_en && (cyc % 10 == 0);
        end
    end

    initial begin
        nRst = 1'b0; start = 1'b0; eat_evt = 1'b0; crash_evt = 1'b0;
        score_cur = 7'd0; score_high = 7'd0;
        step(3);
        check("rst_good_coll", good_coll, 0);
        check("rst_bad_coll", bad_coll, 0);
        check("rst_game_active", game_active, 0);
        check("rst_game_won", game_won, 0);
        check("rst_disp_blank", disp_blank, 0);
        check("rst_disp_value", disp_value, 0);
        check("rst_bcd_tens", bcd_tens, 0);
        check("rst_bcd_ones", bcd_ones, 0);
        nRst = 1'b1;
        step(3);
        check("idle_game_active", game_active, 0);
        check("idle_disp_value", disp_value, 0);

        score_high = 7'd37;
        score_cur  = 7'd5;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("start_game_active", game_active, 1);
        check("play_disp_value", disp_value, 5);
        check("play_bcd_ones", bcd_ones, 5);

        for (int i = 0; i < 3; i++) begin
            pulse_eat();
            step(4);
        end

        tick_en = 1'b1;
        step(3);
        score_cur = 7'd12;
        eat_evt = 1'b1;
        crash_evt = 1'b1;
        crash_cyc = cyc;
        toggle_q.delete();
        exp_q.push_back('{good: 1'b0, bad: 1'b1, at: cyc + 1});
        step(1);
        eat_evt = 1'b0;
        crash_evt = 1'b0;
        score_cur = 7'd0;
        step(1);
        check("crash_game_active", game_active, 0);
        check("crash_game_won", game_won, 0);
        check("crash_disp_value", disp_value, 12);
        check("crash_bcd_tens", bcd_tens, 1);
        check("crash_bcd_ones", bcd_ones, 2);
        eat_evt = 1'b1;
        step(1);
        eat_evt = 1'b0;

        wait_toggles("blink_toggle_count", 6);
        first_tick_edge = crash_cyc + 2;
        while ((first_tick_edge - 1) % 10 != 0) first_tick_edge++;
        if (toggle_q.size() > 0) check("blink_first_toggle", toggle_q[0], first_tick_edge + 30);
        for (int i = 1; i < toggle_q.size(); i++) check("blink_period", toggle_q[i] - toggle_q[i-1], 40);
        step(2);
        check("high_disp_blank", disp_blank, 0);
        check("high_disp_value", disp_value, 37);
        check("high_bcd_tens", bcd_tens, 3);
        check("high_bcd_ones", bcd_ones, 7);

        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("replay_game_active", game_active, 1);
        score_cur = 7'd50;
        toggle_q.delete();
        step(1);
        score_cur = 7'd0;
        step(2);
        check("win_game_won", game_won, 1);
        check("win_game_active", game_active, 0);
        check("win_disp_value", disp_value, 50);
        check("win_bcd_tens", bcd_tens, 5);
        check("win_bcd_ones", bcd_ones, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check("win_start_ignored", game_active, 0);
        check("win_still_won", game_won, 1);
        wait_toggles("win_toggle_count", 6);
        step(2);
        check("win_high_value", disp_value, 37);
        check("win_high_won", game_won, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        check("win_restart_active", game_active, 1);
        check("win_restart_won", game_won, 0);

        score_cur = 7'd20;
        crash_evt = 1'b1;
        exp_q.push_back('{good: 1'b0, bad: 1'b1, at: cyc + 1});
        step(1);
        crash_evt = 1'b0;
        budget = 0;
        while (disp_blank !== 1'b1 && budget < 200) begin
            step(1);
            budget++;
        end
        check("rst_reach_blank", disp_blank, 1);
        step(2);
        #3;
        nRst = 1'b0;
        #1;
        check("midrst_disp_blank", disp_blank, 0);
        check("midrst_game_active", game_active, 0);
        check("midrst_disp_value", disp_value, 0);
        step(2);
        nRst = 1'b1;
        eat_evt = 1'b1;
        step(1);
        eat_evt = 1'b0;
        crash_evt = 1'b1;
        step(1);
        crash_evt = 1'b0;
        step(3);
        check("postrst_idle_value", disp_value, 37);
        check("postrst_game_active", game_active, 0);
        check("postrst_disp_blank", disp_blank, 0);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
